vec_datapath: RTL and testbench

//   Parametrised SIMD datapath: LANES x WIDTH register file, per-lane ALU, lane-mask writes.
//   Two-stage pipeline (EX, WB/OUT) with valid/ready handshake on both sides; successor to
//   the fixed 4-bit datapath. Sits between the instruction decoder and the result consumer.

---
 rtl/vec_dp_pkg.sv | 19 +
 rtl/vec_dp_lane_alu.sv | 29 ++
 rtl/vec_datapath.sv | 141 ++++++++++++++
 tb/tb_vec_datapath.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_dp_pkg.sv
// Shared encodings for the vector datapath: ALU opcodes, operand-B form select and the
// hard-wired zero register index.
package vec_dp_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL1 = 3'd5;
    localparam logic [2:0] OP_SHR1 = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam logic FORM_REG = 1'b0;
    localparam logic FORM_IMM = 1'b1;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/vec_dp_lane_alu.sv
// vec_dp_lane_alu: combinational single-lane ALU; results wrap modulo 2^WIDTH.
// Shifts act on A only with zero fill; PASS forwards B.
module vec_dp_lane_alu
    import vec_dp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL1: y = {a[WIDTH-2:0], 1'b0};
            OP_SHR1: y = {1'b0, a[WIDTH-1:1]};
            OP_PASS: y = b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vec_datapath.sv
// vec_datapath: LANES x WIDTH SIMD register file with per-lane ALU, lane-masked writeback
// and a two-stage (EX, OUT) valid/ready pipeline. Define VEC_DP_BYPASS_EN to forward EX
// results to dependent operands instead of inserting a one-cycle stall.
module vec_datapath
    import vec_dp_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int LANES = 4,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS),
    localparam int VW    = LANES * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             form,
    input  logic [LANES-1:0] vec,
    input  logic [AW-1:0]    rd,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VW-1:0]    out_data,
    output logic [LANES-1:0] out_zero
);

    localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

    logic [VW-1:0]    regs [NREGS];
    logic [VW-1:0]    reg_a, reg_b, opnd_a, opnd_b, alu_y;
    logic [VW-1:0]    old_rd, merged;
    logic [LANES-1:0] merged_zero;
    logic             hazard_a, hazard_b, ex_advance, accept;

    logic             vld_p1;
    logic [VW-1:0]    alu_p1;
    logic [LANES-1:0] vec_p1;
    logic [AW-1:0]    rd_p1;

    logic             vld_p2;
    logic [VW-1:0]    data_p2;
    logic [LANES-1:0] zero_p2;

    function automatic logic [VW-1:0] merge_lanes(input logic [VW-1:0]    new_v,
                                                  input logic [VW-1:0]    old_v,
                                                  input logic [LANES-1:0] mask);
        logic [VW-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++)
            m[i*WIDTH +: WIDTH] = mask[i] ? new_v[i*WIDTH +: WIDTH] : old_v[i*WIDTH +: WIDTH];
        return m;
    endfunction

    function automatic logic [LANES-1:0] lane_zero(input logic [VW-1:0] v);
        logic [LANES-1:0] z;
        z = '0;
        for (int i = 0; i < LANES; i++)
            z[i] = (v[i*WIDTH +: WIDTH] == '0);
        return z;
    endfunction

    always_comb begin
        reg_a       = (ra == R0) ? '0 : regs[ra];
        reg_b       = (rb == R0) ? '0 : regs[rb];
        // Unmasked lanes keep whatever rd holds at writeback time, so the merge happens here.
        old_rd      = (rd_p1 == R0) ? '0 : regs[rd_p1];
        merged      = merge_lanes(alu_p1, old_rd, vec_p1);
        merged_zero = lane_zero(merged);
        ex_advance  = !vld_p2 || out_ready;
        hazard_a    = vld_p1 && (rd_p1 != R0) && (rd_p1 == ra);
        hazard_b    = vld_p1 && (rd_p1 != R0) && (form == FORM_REG) && (rd_p1 == rb);
`ifdef VEC_DP_BYPASS_EN
        opnd_a      = hazard_a ? merged : reg_a;
        opnd_b      = (form == FORM_IMM) ? {LANES{imm}} : (hazard_b ? merged : reg_b);
        in_ready    = !vld_p1 || ex_advance;
`else
        opnd_a      = reg_a;
        opnd_b      = (form == FORM_IMM) ? {LANES{imm}} : reg_b;
        in_ready    = (!vld_p1 || ex_advance) && !(hazard_a || hazard_b);
`endif
        accept      = in_valid && in_ready;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vec_dp_lane_alu #(.WIDTH(WIDTH)) u_alu (
            .op (op),
            .a  (opnd_a[i*WIDTH +: WIDTH]),
            .b  (opnd_b[i*WIDTH +: WIDTH]),
            .y  (alu_y[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (ex_advance && vld_p1 && (rd_p1 != R0)) begin
            regs[rd_p1] <= merged;
        end
    end

    // EX stage: raw per-lane ALU result, mask and destination
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            alu_p1 <= '0;
            vec_p1 <= '0;
            rd_p1  <= '0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            alu_p1 <= alu_y;
            vec_p1 <= vec;
            rd_p1  <= rd;
        end else if (ex_advance) begin
            vld_p1 <= 1'b0;
        end
    end

    // OUT stage: merged result held until the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            zero_p2 <= '0;
        end else if (ex_advance) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= merged;
                zero_p2 <= merged_zero;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_zero  = zero_p2;

endmodule

// File: tb/tb_vec_datapath.sv
// Directed bench for vec_datapath (WIDTH=4, LANES=4, NREGS=8); results are captured into a
// queue on each output handshake and checked against hand-computed values.
module tb_vec_datapath;
    import vec_dp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic        form = 1'b0;
    logic [3:0]  vec = '0;
    logic [2:0]  rd = '0, ra = '0, rb = '0;
    logic [3:0]  imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [3:0]  out_zero;

    int nvec = 0;
    int nerr = 0;
    logic [19:0] rq[$];

`ifdef VEC_DP_BYPASS_EN
    localparam int HAZ_STALLS = 0;
`else
    localparam int HAZ_STALLS = 1;
`endif

    always #5 clk = ~clk;

    vec_datapath #(.WIDTH(4), .LANES(4), .NREGS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .form      (form),
        .vec       (vec),
        .rd        (rd),
        .ra        (ra),
        .rb        (rb),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            rq.push_back({out_zero, out_data});

    function automatic logic [19:0] pop();
        if (rq.size() == 0) return 'x;
        return rq.pop_front();
    endfunction

    // Present one instruction until accepted; called and returns at posedge+1.
    task automatic issue(input logic [2:0] o, input logic f, input logic [3:0] v,
                         input logic [2:0] d, input logic [2:0] a, input logic [2:0] b,
                         input logic [3:0] im, output int stalls);
        bit rdy;
        stalls = 0;
        {op, form, vec, rd, ra, rb, imm} = {o, f, v, d, a, b, im};
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #1;
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            stalls++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, output bit ok);
        for (int c = 0; c < 40 && rq.size() < n; c++) begin
            @(posedge clk);
            #1;
        end
        ok = (rq.size() >= n);
    endtask

    task automatic test_reset();
        int s;
        bit ok;
        logic [19:0] r;
        issue(OP_ADD, FORM_IMM, 4'hF, 3'd2, 3'd0, 3'd0, 4'h7, s);
        issue(OP_ADD, FORM_IMM, 4'hF, 3'd1, 3'd0, 3'd0, 4'h3, s);
        rst = 1'b1;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        nvec++; if (out_data !== 16'h0000) begin nerr++; $display("FAIL rst_out_data got=%h want=0000", out_data); end
        nvec++; if (out_zero !== 4'h0) begin nerr++; $display("FAIL rst_out_zero got=%b want=0000", out_zero); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rq.delete();
        for (int k = 1; k < 8; k++)
            issue(OP_PASS, FORM_REG, 4'hF, 3'd0, 3'd0, 3'(k), 4'h0, s);
        drain(7, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL rst_drain got=%0d want=7", rq.size()); end
        for (int k = 1; k < 8; k++) begin
            r = pop();
            nvec++;
            if (r !== {4'hF, 16'h0000}) begin
                nerr++; $display("FAIL rst_read_r%0d got=%h/%b want=0000/1111", k, r[15:0], r[19:16]);
            end
        end
    endtask

    task automatic test_add_chain();
        int s;
        bit ok;
        logic [19:0] r;
        issue(OP_ADD, FORM_IMM, 4'hF, 3'd1, 3'd0, 3'd0, 4'h3, s);
        issue(OP_ADD, FORM_REG, 4'hF, 3'd2, 3'd1, 3'd1, 4'h0, s);
        drain(2, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL add_drain got=%0d want=2", rq.size()); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h3333}) begin nerr++; $display("FAIL add_imm got=%h/%b want=3333/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h6666}) begin nerr++; $display("FAIL add_reg got=%h/%b want=6666/0000", r[15:0], r[19:16]); end
    endtask

    task automatic test_lane_ops();
        int s;
        bit ok;
        logic [19:0] r;
        issue(OP_XOR,  FORM_IMM, 4'h5, 3'd2, 3'd1, 3'd0, 4'hF, s);
        issue(OP_SUB,  FORM_IMM, 4'hF, 3'd3, 3'd0, 3'd0, 4'h1, s);
        issue(OP_SHL1, FORM_IMM, 4'hF, 3'd3, 3'd3, 3'd0, 4'h0, s);
        issue(OP_SHR1, FORM_IMM, 4'hF, 3'd6, 3'd3, 3'd0, 4'h0, s);
        issue(OP_AND,  FORM_IMM, 4'h3, 3'd6, 3'd3, 3'd0, 4'h0, s);
        drain(5, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL lane_drain got=%0d want=5", rq.size()); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h6C6C}) begin nerr++; $display("FAIL xor_mask got=%h/%b want=6C6C/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'hFFFF}) begin nerr++; $display("FAIL sub_wrap got=%h/%b want=FFFF/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'hEEEE}) begin nerr++; $display("FAIL shl1 got=%h/%b want=EEEE/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h7777}) begin nerr++; $display("FAIL shr1 got=%h/%b want=7777/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'h3, 16'h7700}) begin nerr++; $display("FAIL and_mask got=%h/%b want=7700/0011", r[15:0], r[19:16]); end
    endtask

    task automatic test_back_to_back();
        int s1, s2, s3, s4;
        bit ok;
        logic [19:0] r;
        issue(OP_ADD,  FORM_IMM, 4'hF, 3'd1, 3'd0, 3'd0, 4'h5, s1);
        issue(OP_ADD,  FORM_REG, 4'hF, 3'd4, 3'd1, 3'd1, 4'h0, s2);
        issue(OP_ADD,  FORM_IMM, 4'hF, 3'd7, 3'd0, 3'd4, 4'h2, s3);
        issue(OP_PASS, FORM_REG, 4'hF, 3'd5, 3'd0, 3'd7, 4'h0, s4);
        nvec++; if (s1 !== 0) begin nerr++; $display("FAIL b2b_first_stall got=%0d want=0", s1); end
        nvec++; if (s2 !== HAZ_STALLS) begin nerr++; $display("FAIL b2b_ra_stall got=%0d want=%0d", s2, HAZ_STALLS); end
        nvec++; if (s3 !== 0) begin nerr++; $display("FAIL b2b_imm_no_stall got=%0d want=0", s3); end
        nvec++; if (s4 !== HAZ_STALLS) begin nerr++; $display("FAIL b2b_rb_stall got=%0d want=%0d", s4, HAZ_STALLS); end
        drain(4, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL b2b_drain got=%0d want=4", rq.size()); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h5555}) begin nerr++; $display("FAIL b2b_r1 got=%h/%b want=5555/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'hAAAA}) begin nerr++; $display("FAIL b2b_r4 got=%h/%b want=AAAA/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h2222}) begin nerr++; $display("FAIL b2b_r7 got=%h/%b want=2222/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h2222}) begin nerr++; $display("FAIL b2b_r5 got=%h/%b want=2222/0000", r[15:0], r[19:16]); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int blocked = -1;
        bit rdy, ok;
        logic [19:0] r;
        out_ready = 1'b0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (c == 3) out_ready = 1'b1;
            case (k)
                0: {op, form, vec, rd, ra, rb, imm} = {OP_ADD,  FORM_IMM, 4'hF, 3'd5, 3'd0, 3'd0, 4'h1};
                1: {op, form, vec, rd, ra, rb, imm} = {OP_ADD,  FORM_IMM, 4'hF, 3'd6, 3'd0, 3'd0, 4'h2};
                2: {op, form, vec, rd, ra, rb, imm} = {OP_OR,   FORM_IMM, 4'hF, 3'd7, 3'd0, 3'd0, 4'h9};
                default: {op, form, vec, rd, ra, rb, imm} = {OP_PASS, FORM_IMM, 4'hF, 3'd5, 3'd0, 3'd0, 4'h4};
            endcase
            in_valid = 1'b1;
            #1;
            rdy = in_ready;
            if (c == 2) begin
                nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
                nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
                nvec++; if (out_data !== 16'h1111) begin nerr++; $display("FAIL bp_hold_c2 got=%h want=1111", out_data); end
            end
            if (c == 3) begin
                nvec++; if (out_data !== 16'h1111) begin nerr++; $display("FAIL bp_hold_c3 got=%h want=1111", out_data); end
            end
            @(posedge clk);
            #1;
            if (rdy) k++;
            if (c == 2) blocked = k;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        nvec++; if (blocked !== 2) begin nerr++; $display("FAIL bp_accepts got=%0d want=2", blocked); end
        drain(4, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL bp_drain got=%0d want=4", rq.size()); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h1111}) begin nerr++; $display("FAIL bp_res0 got=%h want=1111", r[15:0]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h2222}) begin nerr++; $display("FAIL bp_res1 got=%h want=2222", r[15:0]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h9999}) begin nerr++; $display("FAIL bp_res2 got=%h want=9999", r[15:0]); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'h4444}) begin nerr++; $display("FAIL bp_res3 got=%h want=4444", r[15:0]); end
    endtask

    task automatic test_zero_reg();
        int s1, s2;
        bit ok;
        logic [19:0] r;
        issue(OP_OR,   FORM_IMM, 4'hF, 3'd0, 3'd0, 3'd0, 4'hF, s1);
        issue(OP_PASS, FORM_REG, 4'hF, 3'd0, 3'd0, 3'd0, 4'h0, s2);
        nvec++; if (s2 !== 0) begin nerr++; $display("FAIL r0_no_stall got=%0d want=0", s2); end
        drain(2, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL r0_drain got=%0d want=2", rq.size()); end
        r = pop();
        nvec++; if (r !== {4'h0, 16'hFFFF}) begin nerr++; $display("FAIL r0_write got=%h/%b want=FFFF/0000", r[15:0], r[19:16]); end
        r = pop();
        nvec++; if (r !== {4'hF, 16'h0000}) begin nerr++; $display("FAIL r0_read got=%h/%b want=0000/1111", r[15:0], r[19:16]); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_add_chain();
        test_lane_ops();
        test_back_to_back();
        test_backpressure();
        test_zero_reg();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
